sram_rr_port_ctrl: RTL and testbench

//  Shares one single-port 32x2048 SRAM macro (RW port 0) between two requesters.

---
 rtl/sram_rr_port_ctrl_if.sv | 24 ++
 rtl/sram_rr_port_ctrl.sv | 118 +++++++++++
 tb/tb_sram_rr_port_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sram_rr_port_ctrl_if.sv
// Two-requester request/response bundle for the shared SRAM port.
// Index 0/1 selects the requester; packed per-port arrays keep the arbiter generic.
interface sram_rr_port_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  logic [1:0]                 valid;
  logic [1:0]                 ready;
  logic [1:0]                 we;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][DATA_WIDTH-1:0] wdata;
  logic [1:0]                 rvalid;
  logic [1:0][DATA_WIDTH-1:0] rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/sram_rr_port_ctrl.sv
// Round-robin sharing of one single-port SRAM between two requesters, with
// fixed two-cycle read responses and a zero-fill sweep after reset or on demand.
module sram_rr_port_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  sram_rr_port_ctrl_if.slave    req,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      cnt_q, cnt_d;
  logic                       rr_q, rr_d;
  logic                       csb_q, csb_d;
  logic                       web_q, web_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      din_q, din_d;
  logic [1:0]                 vld_pipe_q, prt_pipe_q;
  logic [1:0]                 rvalid_q;
  logic [1:0][DATA_WIDTH-1:0] rdata_q;

  logic       gnt_v, gnt_p, rd_issue;
  logic [1:0] ready_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    addr_d  = addr_q;
    din_d   = din_q;
    gnt_v   = 1'b0;
    gnt_p   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        csb_d  = 1'b0;
        web_d  = 1'b0;
        addr_d = cnt_q;
        din_d  = '0;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_RUN;
      end
      default: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          // Contention goes to rr_q; a lone requester wins regardless of rr_q.
          gnt_v = |req.valid;
          gnt_p = (&req.valid) ? rr_q : req.valid[1];
          if (gnt_v) begin
            rr_d   = ~gnt_p;
            csb_d  = 1'b0;
            web_d  = ~req.we[gnt_p];
            addr_d = req.addr[gnt_p];
            din_d  = req.wdata[gnt_p];
          end
        end
      end
    endcase
    ready_w  = {gnt_v & gnt_p, gnt_v & ~gnt_p};
    rd_issue = gnt_v & ~req.we[gnt_p];
  end

  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      csb_q      <= 1'b1;
      web_q      <= 1'b1;
      addr_q     <= '0;
      din_q      <= '0;
      vld_pipe_q <= '0;
      prt_pipe_q <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      csb_q      <= csb_d;
      web_q      <= web_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      // Stage 0 tracks the macro sampling edge, stage 1 the data-capture edge.
      vld_pipe_q <= {vld_pipe_q[0], rd_issue};
      prt_pipe_q <= {prt_pipe_q[0], gnt_p};
      rvalid_q   <= '0;
      if (vld_pipe_q[1]) begin
        rvalid_q[prt_pipe_q[1]] <= 1'b1;
        rdata_q[prt_pipe_q[1]]  <= sram_dout0;
      end
    end
  end

  assign req.ready  = ready_w;
  assign req.rvalid = rvalid_q;
  assign req.rdata  = rdata_q;
  assign busy       = (state_q == ST_CLEAR);
  assign sram_csb0  = csb_q;
  assign sram_web0  = web_q;
  assign sram_addr0 = addr_q;
  assign sram_din0  = din_q;

endmodule

// File: tb/tb_sram_rr_port_ctrl.sv
// Randomized and directed checks of the shared SRAM port against a queue-based
// model of grants, memory contents and due read responses.
module tb_sram_rr_port_ctrl;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int DEPTH = 1 << AW;

  logic clk0 = 1'b0;
  logic rstb0 = 1'b0;
  logic clear_req = 1'b0;
  logic busy, sram_csb0, sram_web0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0, sram_dout0;

  sram_rr_port_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_rr_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk0(clk0), .rstb0(rstb0), .req(bus), .clear_req(clear_req), .busy(busy),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  always #5 clk0 = ~clk0;

  // Macro stand-in: samples on posedge, read data appears before the next edge.
  logic [DW-1:0] macro_mem [DEPTH];
  always @(posedge clk0) begin
    if (!sram_csb0) begin
      if (!sram_web0) macro_mem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= macro_mem[sram_addr0];
    end
  end

  typedef struct { int due; bit port; logic [DW-1:0] data; } resp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int clear_left = 0;
  bit pref = 0;
  bit g_v, g_p;
  resp_t exp_q[$];
  logic [DW-1:0] mem_m [DEPTH];
  logic [1:0][DW-1:0] m_rd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit e_csb, e_web, e_busy, e_rv;
    @(negedge clk0);
    g_v = 1'b0;
    g_p = 1'b0;
    if (rstb0) begin
      if (clear_left == 0 && !clear_req) begin
        g_v = |bus.valid;
        g_p = (&bus.valid) ? pref : bus.valid[1];
      end
      chk("ready0", {31'd0, bus.ready[0]}, {31'd0, g_v & ~g_p});
      chk("ready1", {31'd0, bus.ready[1]}, {31'd0, g_v & g_p});
    end
    @(posedge clk0);
    cyc++;
    e_csb = 1'b1;
    e_web = 1'b1;
    if (!rstb0) begin
      exp_q.delete();
      m_rd = '0;
      pref = 1'b0;
      m_addr = '0;
      m_din = '0;
      clear_left = DEPTH;
      foreach (mem_m[i]) mem_m[i] = '0;
    end else if (clear_left > 0) begin
      e_csb = 1'b0;
      e_web = 1'b0;
      m_addr = AW'(DEPTH - clear_left);
      m_din = '0;
      clear_left--;
    end else if (clear_req) begin
      clear_left = DEPTH;
      foreach (mem_m[i]) mem_m[i] = '0;
    end else if (g_v) begin
      e_csb = 1'b0;
      e_web = ~bus.we[g_p];
      m_addr = bus.addr[g_p];
      m_din = bus.wdata[g_p];
      if (bus.we[g_p]) mem_m[m_addr] = m_din;
      else exp_q.push_back('{cyc + 2, g_p, mem_m[m_addr]});
      pref = ~g_p;
    end
    e_busy = (clear_left > 0);
    #1;
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("csb", {31'd0, sram_csb0}, {31'd0, e_csb});
    chk("web", {31'd0, sram_web0}, {31'd0, e_web});
    chk("addr", {21'd0, sram_addr0}, {21'd0, m_addr});
    chk("din", sram_din0, m_din);
    for (int p = 0; p < 2; p++) begin
      e_rv = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc && exp_q[0].port == p[0]) begin
        e_rv = 1'b1;
        m_rd[p] = exp_q[0].data;
        void'(exp_q.pop_front());
      end
      chk(p == 0 ? "rvalid0" : "rvalid1", {31'd0, bus.rvalid[p]}, {31'd0, e_rv});
      chk(p == 0 ? "rdata0" : "rdata1", bus.rdata[p], m_rd[p]);
    end
  endtask

  task automatic step(input bit v0, input bit w0, input int a0, input logic [DW-1:0] d0,
                      input bit v1, input bit w1, input int a1, input logic [DW-1:0] d1,
                      input bit clr);
    bus.valid = {v1, v0};
    bus.we    = {w1, w0};
    bus.addr  = {AW'(a1), AW'(a0)};
    bus.wdata = {d1, d0};
    clear_req = clr;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd(input int n, input int amask);
    for (int i = 0; i < n; i++)
      step($urandom_range(9) < 7, $urandom_range(1) == 1, int'($urandom) & amask, $urandom,
           $urandom_range(9) < 7, $urandom_range(1) == 1, int'($urandom) & amask, $urandom, 0);
  endtask

  initial begin
    int a0, a1;
    bus.valid = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    // Reset and the power-on sweep, with requests knocking during it
    repeat (3) tick();
    rstb0 = 1'b1;
    rnd(DEPTH, 15);
    idle(1);
    // Read after sweep, then write/read of the same word
    step(1, 0, 5, 0, 0, 0, 0, 0, 0);
    step(1, 1, 'h010, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(1, 0, 'h010, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Both ports streaming reads; each advances only when granted
    a0 = 1; a1 = 2;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, a0, 0, 1, 0, a1, 0, 0);
      if (g_v && !g_p) a0 += 2;
      if (g_v && g_p) a1 += 2;
    end
    idle(3);
    // Pointer set toward p1, then write/read collision on the top word
    step(1, 0, 3, 0, 0, 0, 0, 0, 0);
    step(1, 0, 'h7FF, 0, 1, 1, 'h7FF, 32'h12345678, 0);
    step(1, 0, 'h7FF, 0, 0, 0, 0, 0, 0);
    idle(3);
    rnd(400, 15);
    idle(3);
    // On-demand sweep with a read still in flight
    step(1, 0, 'h010, 0, 0, 0, 0, 0, 0);
    step(1, 0, 'h010, 0, 1, 1, 'h010, 32'hA5A5A5A5, 1);
    rnd(DEPTH, 31);
    step(1, 0, 'h010, 0, 0, 0, 0, 0, 0);
    idle(3);
    rnd(100, 7);
    // Reset right after a read accept drops its response
    step(0, 0, 0, 0, 1, 0, 3, 0, 0);
    rstb0 = 1'b0;
    idle(1);
    rstb0 = 1'b1;
    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
